// File: rtl/inc_share_ctrl_if.sv
// rtl/inc_share_ctrl_if.sv - request/response bundle between requesters, consumer and inc_share_ctrl
interface inc_share_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [CNTW-1:0]  req0_cnt;
  logic             req0_neg;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [CNTW-1:0]  req1_cnt;
  logic             req1_neg;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_ovf;

  // controller side
  modport slave (
    input  req0_valid, req0_data, req0_cnt, req0_neg,
    output req0_ready,
    input  req1_valid, req1_data, req1_cnt, req1_neg,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_ovf,
    input  rsp_ready
  );

  // requester / consumer side
  modport master (
    output req0_valid, req0_data, req0_cnt, req0_neg,
    input  req0_ready,
    output req1_valid, req1_data, req1_cnt, req1_neg,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_ovf,
    output rsp_ready
  );
endinterface

// File: rtl/inc_share_ctrl.sv
// rtl/inc_share_ctrl.sv - round-robin sequencer for the shared incrementer (optional stats: INC_SHARE_STATS_EN)
module inc_share_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  inc_share_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] inc_a,
  input  logic [WIDTH-1:0] inc_b
`ifdef INC_SHARE_STATS_EN
  ,
  output logic [7:0]       stat_grant0,
  output logic [7:0]       stat_grant1,
  output logic [15:0]      stat_busy
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNTW:0]    iter;
  logic             rr_ptr;
  logic             ovf_flag;

  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] sel_data;
  logic [CNTW-1:0]  sel_cnt;
  logic             sel_neg;
  logic [WIDTH-1:0] acc_load;
  logic [CNTW:0]    n_load;
  logic             ovf_next;

  assign inc_a = acc;

  // grant the valid requester; rr_ptr breaks ties, never grant outside IDLE or in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = !rr_ptr;
        gnt1 = rr_ptr;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // operand mux from the grantee and the values loaded on accept
  always_comb begin
    sel_data = gnt1 ? bus.req1_data : bus.req0_data;
    sel_cnt  = gnt1 ? bus.req1_cnt  : bus.req0_cnt;
    sel_neg  = gnt1 ? bus.req1_neg  : bus.req0_neg;
    acc_load = sel_neg ? ~sel_data : sel_data;
    n_load   = {1'b0, sel_cnt} + {{CNTW{1'b0}}, sel_neg};
    ovf_next = ovf_flag | (acc == {WIDTH{1'b1}});
  end

  // sequencer: accept, run N incrementer passes, hold the response until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      iter      <= '0;
      rr_ptr    <= 1'b0;
      ovf_flag  <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            acc        <= acc_load;
            iter       <= n_load;
            bus.rsp_id <= gnt1;
            ovf_flag   <= 1'b0;
            if (n_load != '0) begin
              state <= RUN;
            end else begin
              // nothing to run: the loaded operand is the answer
              state         <= DONE;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= acc_load;
              bus.rsp_ovf   <= 1'b0;
            end
          end
        end
        RUN: begin
          acc      <= inc_b;
          iter     <= iter - 1'b1;
          ovf_flag <= ovf_next;
          if (iter == (CNTW+1)'(1)) begin
            state         <= DONE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= inc_b;
            bus.rsp_ovf   <= ovf_next;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            rr_ptr        <= ~bus.rsp_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INC_SHARE_STATS_EN
  // saturating grant and busy-cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_busy   <= '0;
    end else begin
      if (gnt0 && stat_grant0 != 8'hFF)
        stat_grant0 <= stat_grant0 + 8'd1;
      if (gnt1 && stat_grant1 != 8'hFF)
        stat_grant1 <= stat_grant1 + 8'd1;
      if (state == RUN && stat_busy != 16'hFFFF)
        stat_busy <= stat_busy + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inc_share_ctrl.sv
// tb/tb_inc_share_ctrl.sv - directed self-checking bench for inc_share_ctrl
module tb_inc_share_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inc_a;
  logic [7:0] inc_b;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // behavioural model of the shared ripple incrementer
  assign inc_b = inc_a + 8'd1;

  inc_share_ctrl_if bus ();

`ifdef INC_SHARE_STATS_EN
  logic [7:0]  stat_grant0;
  logic [7:0]  stat_grant1;
  logic [15:0] stat_busy;
`endif

  inc_share_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .inc_a (inc_a),
    .inc_b (inc_b)
`ifdef INC_SHARE_STATS_EN
    ,
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
    .stat_busy   (stat_busy)
`endif
  );

  // issue one request, measure accept-to-valid latency, check the response
  task automatic do_req(input logic id, input logic [7:0] d, input logic [3:0] c,
                        input logic n, input logic [7:0] ed, input logic eo,
                        input int elat, input bit hs);
    int lat;
    logic rdy;
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_cnt = c; bus.req1_neg = n;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_cnt = c; bus.req0_neg = n;
    end
    #1;
    rdy = id ? bus.req1_ready : bus.req0_ready;
    checks++;
    if (rdy !== 1'b1) begin errors++; $error("FAIL req_ready observed %0h", rdy); end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_data = 8'hA5; bus.req1_data = 8'h5A;
    bus.req0_cnt = 4'hF; bus.req1_cnt = 4'hF;
    bus.req0_neg = 1'b1; bus.req1_neg = 1'b1;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != elat) begin errors++; $error("FAIL latency observed %0d expected %0d", lat, elat); end
    checks++;
    if (bus.rsp_data !== ed) begin errors++; $error("FAIL rsp_data observed %0h expected %0h", bus.rsp_data, ed); end
    checks++;
    if (bus.rsp_id !== id) begin errors++; $error("FAIL rsp_id observed %0h expected %0h", bus.rsp_id, id); end
    checks++;
    if (bus.rsp_ovf !== eo) begin errors++; $error("FAIL rsp_ovf observed %0h expected %0h", bus.rsp_ovf, eo); end
    if (hs) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin errors++; $error("FAIL rsp_drop"); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  seen;
    logic [7:0] ed;
    logic       eid;

    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h00; bus.req0_cnt = 4'h0; bus.req0_neg = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_cnt = 4'h0; bus.req1_neg = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $error("FAIL rst_rsp_valid"); end
    checks++;
    if (bus.rsp_data !== 8'h00) begin errors++; $error("FAIL rst_rsp_data %0h", bus.rsp_data); end
    checks++;
    if (bus.rsp_id !== 1'b0) begin errors++; $error("FAIL rst_rsp_id"); end
    checks++;
    if (bus.rsp_ovf !== 1'b0) begin errors++; $error("FAIL rst_rsp_ovf"); end
    checks++;
    if (bus.req0_ready !== 1'b0) begin errors++; $error("FAIL rst_ready0"); end
    checks++;
    if (inc_a !== 8'h00) begin errors++; $error("FAIL rst_inc_a %0h", inc_a); end
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // add, negate, negate-of-zero wrap
    do_req(1'b0, 8'h10, 4'd3, 1'b0, 8'h13, 1'b0, 4, 1'b1);
    do_req(1'b1, 8'h05, 4'd0, 1'b1, 8'hFB, 1'b0, 2, 1'b1);
    do_req(1'b1, 8'h00, 4'd0, 1'b1, 8'h00, 1'b1, 2, 1'b1);

    // both requesters valid continuously: grants must alternate 0,1,0,1
    bus.req0_valid = 1'b1; bus.req0_data = 8'h20; bus.req0_cnt = 4'd0; bus.req0_neg = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h30; bus.req1_cnt = 4'd0; bus.req1_neg = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      do begin
        @(posedge clk);
        #1;
        w++;
        checks++;
        if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin errors++; $error("FAIL ready_excl"); end
      end while (!bus.rsp_valid && w < 10);
      ed  = (k % 2 == 0) ? 8'h20 : 8'h30;
      eid = ((k % 2) == 1);
      checks++;
      if (bus.rsp_valid !== 1'b1) begin errors++; $error("FAIL arb_valid"); end
      checks++;
      if (bus.rsp_id !== eid) begin errors++; $error("FAIL arb_id observed %0h expected %0h", bus.rsp_id, eid); end
      checks++;
      if (bus.rsp_data !== ed) begin errors++; $error("FAIL arb_data observed %0h expected %0h", bus.rsp_data, ed); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $error("FAIL arb_drop"); end

    // wrap through all-ones, then zero-pass pass-through
    do_req(1'b0, 8'hFE, 4'd3, 1'b0, 8'h01, 1'b1, 4, 1'b1);
    do_req(1'b0, 8'h42, 4'd0, 1'b0, 8'h42, 1'b0, 1, 1'b1);

    // consumer stalls: response stays put, nobody is granted
    do_req(1'b1, 8'h07, 4'd1, 1'b0, 8'h08, 1'b0, 2, 1'b0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1) begin errors++; $error("FAIL stall_valid"); end
      checks++;
      if (bus.rsp_data !== 8'h08) begin errors++; $error("FAIL stall_data %0h", bus.rsp_data); end
      checks++;
      if (bus.rsp_id !== 1'b1) begin errors++; $error("FAIL stall_id"); end
      checks++;
      if (bus.rsp_ovf !== 1'b0) begin errors++; $error("FAIL stall_ovf"); end
      checks++;
      if (bus.req0_ready !== 1'b0) begin errors++; $error("FAIL stall_ready0"); end
      checks++;
      if (bus.req1_ready !== 1'b0) begin errors++; $error("FAIL stall_ready1"); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $error("FAIL stall_drop"); end

    // reset in the second RUN cycle of a cnt=15 request
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = 8'h00; bus.req0_cnt = 4'hF; bus.req0_neg = 1'b0;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (inc_a !== 8'h01) begin errors++; $error("FAIL mid_run_acc %0h", inc_a); end
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $error("FAIL abort_rsp_valid"); end
    checks++;
    if (inc_a !== 8'h00) begin errors++; $error("FAIL abort_inc_a %0h", inc_a); end
    checks++;
    if (bus.rsp_id !== 1'b0) begin errors++; $error("FAIL abort_rsp_id"); end
    checks++;
    if (bus.req0_ready !== 1'b0) begin errors++; $error("FAIL abort_ready0"); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $error("FAIL no_rsp_after_abort"); end

    // traffic after the abort, also used for the statistics counters
    do_req(1'b1, 8'h33, 4'd2, 1'b0, 8'h35, 1'b0, 3, 1'b1);
    do_req(1'b0, 8'h80, 4'd2, 1'b0, 8'h82, 1'b0, 3, 1'b1);
    do_req(1'b0, 8'h80, 4'd2, 1'b0, 8'h82, 1'b0, 3, 1'b1);
    do_req(1'b0, 8'h80, 4'd2, 1'b0, 8'h82, 1'b0, 3, 1'b1);
    do_req(1'b1, 8'hFF, 4'd2, 1'b0, 8'h01, 1'b1, 3, 1'b1);

`ifdef INC_SHARE_STATS_EN
    checks++;
    if (stat_grant0 !== 8'd3) begin errors++; $error("FAIL stat_grant0 %0d", stat_grant0); end
    checks++;
    if (stat_grant1 !== 8'd2) begin errors++; $error("FAIL stat_grant1 %0d", stat_grant1); end
    checks++;
    if (stat_busy !== 16'd10) begin errors++; $error("FAIL stat_busy %0d", stat_busy); end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inc_share_ctrl.md
Name: inc_share_ctrl

Overview:
- Sequencer and arbiter for the processor's single shared 8-bit ripple incrementer, which computes out = in + 1.
- Two requesters share it: requester 0 is PC/counter update, requester 1 is the register-negate/adjust path.
- Each request asks for "add N" or "two's-complement negate plus N". The block runs this as N back-to-back passes through the incrementer, then returns the result on a valid/ready response port.

Parameters:
- WIDTH, 8, datapath width; must match the incrementer instance.
- CNTW, 4, width of the per-request repeat count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_data  input  WIDTH  requester 0 operand
- req0_cnt  input  CNTW  requester 0 repeat count
- req0_neg  input  1  requester 0 negate flag
- req1_valid / req1_ready / req1_data / req1_cnt / req1_neg  same as requester 0, for requester 1
- inc_a  output  WIDTH  operand driven to the shared incrementer
- inc_b  input  WIDTH  incrementer result (combinational, inc_a + 1)
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes the result
- rsp_data  output  WIDTH  result
- rsp_id  output  1  index of the requester that owns the result
- rsp_ovf  output  1  at least one pass wrapped from all-ones to zero

Behaviour:
- States: IDLE, RUN, DONE. Reset (asynchronous, immediate) values:
  - state=IDLE, acc=0, iter=0, rr_ptr=0
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0
  - req0_ready=0, req1_ready=0
- inc_a is always driven from acc.
- IDLE, arbitration:
  - Round-robin. Requester rr_ptr has priority when both valid are high.
  - Exactly one reqX_ready is asserted, combinationally, for the granted valid requester. Both ready are 0 if no request is valid. Ready is never asserted outside IDLE.
- On accept (valid & ready):
  - acc <= neg ? ~data : data
  - N = cnt + neg; iter <= N (width CNTW+1, so N = 0..2^CNTW)
  - rsp_id <= grantee; ovf_flag <= 0
  - Next state: RUN if N != 0, else DONE.
- RUN, one pass per cycle:
  - acc <= inc_b; iter <= iter - 1
  - ovf_flag sets if acc == all-ones in that pass
  - When iter == 1, the final pass is written and the next state is DONE.
  - Latency from accept to rsp_valid is N + 1 cycles; N = 0 gives 1 cycle.
- DONE:
  - rsp_valid=1; rsp_data=acc; rsp_ovf=ovf_flag.
  - These hold stable until rsp_ready=1.
  - On handshake: IDLE, rsp_valid drops the next cycle, rr_ptr <= ~rsp_id.
  - There is no acceptance in the handshake cycle; a new grant happens in IDLE, one cycle later.
- Boundary rules:
  - Request inputs are sampled only at accept; changes afterwards are ignored.
  - A requester dropping valid before accept is permitted and causes no grant.
  - rsp_ready while not in DONE is ignored.
  - Arithmetic is modulo 2^WIDTH; wrap sets ovf and continues.
  - Negate of 0 with cnt 0 gives rsp_data=0, ovf=1.
  - Reset asserted mid-RUN or in DONE aborts the operation, no response is produced, and all state returns to reset values.

Optional Feature:
- Macro: INC_SHARE_STATS_EN.
- Defined: adds outputs stat_grant0 and stat_grant1 (8 bits each) and stat_busy (16 bits), reset to 0.
  - stat_grantX increments on each accept of requester X and saturates at 255.
  - stat_busy counts cycles spent in RUN and saturates at 65535.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then req0 data=0x10, cnt=3, neg=0 -> req0_ready=1 same cycle; rsp_valid 4 cycles after accept; rsp_data=0x13, rsp_id=0, rsp_ovf=0.
- req1 data=0x05, cnt=0, neg=1 -> after 2 cycles rsp_data=0xFB, rsp_id=1, ovf=0. Then data=0x00, cnt=0, neg=1 -> rsp_data=0x00, ovf=1.
- req0 data=0xFE, cnt=3 -> rsp_data=0x01, ovf=1. Then data=0x42, cnt=0, neg=0 -> rsp_data=0x42 after 1 cycle, ovf=0.
- Both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1. With rsp_ready held 0 for 5 cycles, rsp_* stay stable and both ready stay 0.
- Assert rst in the 2nd RUN cycle of a cnt=15 request -> outputs are reset values immediately; no rsp_valid after release; the next request completes correctly.
- With INC_SHARE_STATS_EN: 3 req0 and 2 req1 transactions of cnt=2 -> stat_grant0=3, stat_grant1=2, stat_busy=10.
